// File: rtl/minv_pkg.sv
`default_nettype none
// ============================================================================
// Package   : minv_pkg
// Purpose   : Shared constants, bank encodings and FSM state type for the
//             modular-inverse result reader.
// Revision  : 1.0 - initial release
// ============================================================================
package minv_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;

  localparam logic REGX1_SEL = 1'b0;
  localparam logic REGX2_SEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAP  = 2'd2,
    HOLD = 2'd3
  } minv_rd_state_t;

endpackage
`default_nettype wire

// File: rtl/minv_out_stage.sv
`default_nettype none
// ============================================================================
// Module    : minv_out_stage
// Purpose   : Valid/ready output holding register (data, last, valid).
// Revision  : 1.0 - initial release
// ============================================================================
module minv_out_stage #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              accept
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign accept = valid_q & out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (accept) begin
      // data/last are left as-is; they are only meaningful while valid
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/minv_result_reader.sv
`default_nettype none
// ============================================================================
// Module    : minv_result_reader
// Purpose   : Reads minv from bank regx1/regx2 (chosen by minv_flag) and
//             streams it LSW first over valid/ready. Optional zero check
//             enabled by macro MINV_RD_ZERO_CHK_EN.
// Revision  : 1.0 - initial release
// ============================================================================
module minv_result_reader #(
  parameter int WORD_W    = minv_pkg::WORD_W,
  parameter int NUM_WORDS = minv_pkg::NUM_WORDS,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              minv_flag,
  output logic              busy,
  output logic              done,
  output logic              rf_rd_en,
  output logic              rf_rd_sel,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [WORD_W-1:0] rf_rd_data,
`ifdef MINV_RD_ZERO_CHK_EN
  output logic              zero_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  import minv_pkg::*;

  minv_rd_state_t    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              cap_en;
  logic              accept;
  logic              last_word;

  assign last_word = (cnt_q == ADDR_W'(NUM_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    done_d     = 1'b0;
    cap_en     = 1'b0;
    rf_rd_en   = 1'b0;
    rf_rd_sel  = REGX1_SEL;
    rf_rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = minv_flag ? REGX2_SEL : REGX1_SEL;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        rf_rd_en   = 1'b1;
        rf_rd_sel  = sel_q;
        rf_rd_addr = cnt_q;
        state_d    = CAP;
      end
      CAP: begin
        cap_en  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (accept) begin
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= REGX1_SEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  minv_out_stage #(
    .WORD_W (WORD_W)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cap_en),
    .load_data (rf_rd_data),
    .load_last (last_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .accept    (accept)
  );

`ifdef MINV_RD_ZERO_CHK_EN
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              zero_err_q, zero_err_d;

  // An all-zero accumulator at the final handshake means minv == 0, which has no inverse
  always_comb begin
    acc_d      = acc_q;
    zero_err_d = done_d & (acc_q == '0);
    if ((state_q == IDLE) && start) begin
      acc_d = '0;
    end else if (cap_en) begin
      acc_d = acc_q | rf_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      zero_err_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign zero_err = zero_err_q;
`endif

endmodule
`default_nettype wire
